// File: rtl/pipe_mon_pkg.sv
// Shared types and constants for the pipe equivalence monitor.
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2
  } mon_state_e;

  // Deepest upstream register latency the monitor is built for.
  localparam int unsigned MAX_LAT = 3;

endpackage

// File: rtl/pipe_equiv_monitor_delay_line.sv
// 1-bit shift register aligning a combinational bit with its registered copy.
module delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic d,
  output logic q
);

  logic             in_bit;
  logic [DEPTH-1:0] sr;

  // Upstream flush feeds zeros, matching the upstream register reset value.
  assign in_bit = flush ? 1'b0 : d;

  // Shift one position every clock; oldest sample sits in the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= DEPTH'({sr, in_bit});
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/pipe_equiv_monitor.sv
// Compares delayed combinational outputs of the upstream stage against its
// registered outputs; counts mismatches and latches the first failing pattern.
module pipe_equiv_monitor
  import pipe_mon_pkg::*;
#(
  parameter int unsigned LAT_X = 1,
  parameter int unsigned LAT_Y = 2,
  parameter int unsigned LAT_Z = 3,
  parameter int unsigned WARM  = MAX_LAT,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_rst,
  input  logic             start,
  input  logic             clr,
  input  logic             xb,
  input  logic             yb,
  input  logic             zb,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             checking,
  output logic             mismatch,
  output logic             fail,
  output logic [2:0]       fail_bits,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned WARM_W = (WARM > 2) ? $clog2(WARM) : 1;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARM - 1);

  logic              xd, yd, zd;
  logic [2:0]        diff;
  logic              cmp_en;
  logic              hit;
  mon_state_e        state_q, state_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              mismatch_d, fail_d;
  logic [2:0]        fail_bits_d;
  logic [CNT_W-1:0]  err_cnt_d;

  delay_line #(.DEPTH(LAT_X)) u_dl_x (.clk(clk), .rst_n(rst_n), .flush(up_rst), .d(xb), .q(xd));
  delay_line #(.DEPTH(LAT_Y)) u_dl_y (.clk(clk), .rst_n(rst_n), .flush(up_rst), .d(yb), .q(yd));
  delay_line #(.DEPTH(LAT_Z)) u_dl_z (.clk(clk), .rst_n(rst_n), .flush(up_rst), .d(zb), .q(zd));

  assign diff = {z ^ zd, y ^ yd, x ^ xd};
  assign hit  = cmp_en && (diff != 3'b000);

  // Next state and warm-up count; clr beats up_rst beats start.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cmp_en  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      warm_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !up_rst) begin
            state_d = WARMUP;
            warm_d  = WARM_LOAD;
          end
        end
        WARMUP: begin
          if (up_rst) begin
            warm_d = WARM_LOAD;
          end else if (warm_q == '0) begin
            state_d = CHECK;
          end else begin
            warm_d = warm_q - WARM_W'(1);
          end
        end
        CHECK: begin
          if (up_rst) begin
            state_d = WARMUP;
            warm_d  = WARM_LOAD;
          end else begin
            cmp_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the mismatch pulse, saturating count and sticky flags.
  always_comb begin
    mismatch_d  = hit;
    fail_d      = fail | hit;
    fail_bits_d = (hit && !fail) ? diff : fail_bits;
    err_cnt_d   = (hit && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
    if (clr) begin
      mismatch_d  = 1'b0;
      fail_d      = 1'b0;
      fail_bits_d = 3'b000;
      err_cnt_d   = '0;
    end
  end

  // State, counters and all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      warm_q    <= '0;
      checking  <= 1'b0;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      fail_bits <= 3'b000;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      checking  <= (state_d == CHECK);
      mismatch  <= mismatch_d;
      fail      <= fail_d;
      fail_bits <= fail_bits_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_equiv_monitor.sv
// Scoreboard bench: an upstream stage model drives the monitor, a reference
// model of the monitor's rules queues expected outputs, a monitor process checks.
module tb_pipe_equiv_monitor;

  localparam int unsigned LX   = 1;
  localparam int unsigned LY   = 2;
  localparam int unsigned LZ   = 3;
  localparam int unsigned WARM = 3;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic          chk;
    logic          mis;
    logic          fail;
    logic [2:0]    bits;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          up_rst = 1'b0, start = 1'b0, clr = 1'b0;
  logic          xb = 1'b0, yb = 1'b0, zb = 1'b0;
  logic          x = 1'b0, y = 1'b0, z = 1'b0;
  logic          checking, mismatch, fail;
  logic [2:0]    fail_bits;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Upstream stage registers (synchronous reset via up_rst).
  logic       ux = 1'b0;
  logic [1:0] uy = 2'b00;
  logic [2:0] uz = 3'b000;

  // Reference model state.
  bit   qx[$], qy[$], qz[$];
  bit   m_armed, m_chk, m_mis, m_fail;
  int   m_since, m_cnt;
  bit [2:0] m_bits;
  exp_t sb[$];

  pipe_equiv_monitor #(
    .LAT_X(LX), .LAT_Y(LY), .LAT_Z(LZ), .WARM(WARM), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up_rst(up_rst), .start(start), .clr(clr),
    .xb(xb), .yb(yb), .zb(zb), .x(x), .y(y), .z(z),
    .checking(checking), .mismatch(mismatch), .fail(fail),
    .fail_bits(fail_bits), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qx.delete(); qy.delete(); qz.delete();
    repeat (LX) qx.push_back(1'b0);
    repeat (LY) qy.push_back(1'b0);
    repeat (LZ) qz.push_back(1'b0);
    m_armed = 0; m_chk = 0; m_mis = 0; m_fail = 0;
    m_since = 0; m_cnt = 0; m_bits = 3'b000;
  endtask

  // Called at a falling edge: advance upstream, drive new inputs, predict.
  task automatic step_body(input logic st, input logic cl, input logic ur, input logic [2:0] inj);
    bit [2:0] diff;
    bit       hit;
    exp_t     e;
    if (up_rst) begin
      ux = 1'b0; uy = 2'b00; uz = 3'b000;
    end else begin
      ux = xb; uy = {uy[0], yb}; uz = {uz[1:0], zb};
    end
    xb = 1'($urandom_range(0, 1));
    yb = 1'($urandom_range(0, 1));
    zb = 1'($urandom_range(0, 1));
    start = st; clr = cl; up_rst = ur;
    x = ux ^ inj[0];
    y = uy[1] ^ inj[1];
    z = uz[2] ^ inj[2];

    // Registered output should equal its combinational source LAT cycles ago.
    diff = {bit'(z) ^ qz[0], bit'(y) ^ qy[0], bit'(x) ^ qx[0]};
    hit  = m_chk && !cl && !ur && (diff != 3'b000);
    if (cl) begin
      m_armed = 0; m_since = 0; m_mis = 0; m_fail = 0; m_cnt = 0; m_bits = 3'b000;
    end else begin
      m_mis = hit;
      if (hit) begin
        if (m_cnt < MAXC) m_cnt++;
        if (!m_fail) begin m_fail = 1; m_bits = diff; end
      end
      if (!m_armed) begin
        if (st && !ur) begin m_armed = 1; m_since = 0; end
      end else if (ur) begin
        m_since = 0;
      end else if (m_since < int'(WARM)) begin
        m_since++;
      end
    end
    m_chk = m_armed && (m_since >= int'(WARM));

    qx.push_back(ur ? 1'b0 : bit'(xb)); void'(qx.pop_front());
    qy.push_back(ur ? 1'b0 : bit'(yb)); void'(qy.pop_front());
    qz.push_back(ur ? 1'b0 : bit'(zb)); void'(qz.pop_front());

    e.chk = m_chk; e.mis = m_mis; e.fail = m_fail; e.bits = m_bits; e.cnt = CW'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic step(input logic st, input logic cl, input logic ur, input logic [2:0] inj);
    @(negedge clk);
    step_body(st, cl, ur, inj);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_checking"}, int'(checking), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_fail_bits"}, int'(fail_bits), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // Asynchronous reset asserted mid-cycle, held across one rising edge.
  task automatic pulse_reset();
    step(1'b0, 1'b0, 1'b0, 3'b000);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step_body(1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // Monitor: compare each registered output set against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("checking", int'(checking), int'(e.chk));
      chk("mismatch", int'(mismatch), int'(e.mis));
      chk("fail", int'(fail), int'(e.fail));
      chk("fail_bits", int'(fail_bits), int'(e.bits));
      chk("err_cnt", int'(err_cnt), int'(e.cnt));
    end
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("init_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step_body(1'b0, 1'b0, 1'b1, 3'b000);

    // Clean pipe: flush, arm, long error-free run.
    repeat (3) step(1'b0, 1'b0, 1'b1, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    repeat (200) step(1'b0, 1'b0, 1'b0, 3'b000);

    // Single-cycle error on x.
    step(1'b0, 1'b0, 1'b0, 3'b001);
    repeat (5) step(1'b0, 1'b0, 1'b0, 3'b000);

    // Two-cycle flush during CHECK, start ignored while armed.
    repeat (2) step(1'b0, 1'b0, 1'b1, 3'b000);
    repeat (6) step(1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    repeat (4) step(1'b0, 1'b0, 1'b0, 3'b000);

    // Saturation: clear, re-arm, hold y inverted for 20 compares.
    step(1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    repeat (4) step(1'b0, 1'b0, 1'b0, 3'b000);
    repeat (20) step(1'b0, 1'b0, 1'b0, 3'b010);
    repeat (5) step(1'b0, 1'b0, 1'b0, 3'b000);

    // clr and start together in CHECK: clr wins, IDLE ignores errors.
    step(1'b1, 1'b1, 1'b0, 3'b000);
    repeat (5) step(1'b0, 1'b0, 1'b0, 3'b111);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    repeat (5) step(1'b0, 1'b0, 1'b0, 3'b000);
    repeat (3) step(1'b0, 1'b0, 1'b0, 3'b100);

    // Async reset mid-CHECK with a nonzero count.
    pulse_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 3'b011);

    // Randomized control and error injection.
    for (int i = 0; i < 400; i++) begin
      logic       st, cl, ur;
      logic [2:0] inj;
      st  = ($urandom_range(0, 7) == 0);
      cl  = ($urandom_range(0, 39) == 0);
      ur  = ($urandom_range(0, 15) == 0);
      inj = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(st, cl, ur, inj);
    end

    step(1'b0, 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
